data_ram_arbiter: RTL

//  Shares the single-port data RAM between two requesters: port 0 (CPU MEM stage load/store)
//  and port 1 (secondary master: DMA/debug). Port 0 has fixed priority; a starvation counter

---
 rtl/data_ram_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single-port data RAM between the MEM stage (port 0) and a secondary master (port 1)
module data_ram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        stallreq_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant;
    logic             contested;
    logic             pick;
    assign contested  = m0_req_i & m1_req_i;
    assign pick       = contested ? (starve_cnt == CNT_W'(STARVE_LIMIT)) : m1_req_i;
    assign stallreq_o = m0_req_i & ~m0_ack_o;
    // Arbitration FSM; the RAM command registers double as the ram_*_o outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            grant      <= 1'b0;
            ram_ce_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_sel_o  <= '0;
            ram_data_o <= '0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_data_o  <= '0;
            m1_data_o  <= '0;
        end else begin
            case (state)
                IDLE: if (m0_req_i | m1_req_i) begin
                    state      <= ACCESS;
                    grant      <= pick;
                    ram_ce_o   <= 1'b1;
                    ram_we_o   <= pick ? m1_we_i   : m0_we_i;
                    ram_addr_o <= pick ? m1_addr_i : m0_addr_i;
                    ram_sel_o  <= pick ? m1_sel_i  : m0_sel_i;
                    ram_data_o <= pick ? m1_data_i : m0_data_i;
                    starve_cnt <= (pick || !contested) ? '0 :
                                  (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
                end
                ACCESS: begin
                    state    <= RESP;
                    ram_ce_o <= 1'b0;
                    ram_we_o <= 1'b0;
                    if (grant) begin
                        m1_ack_o  <= 1'b1;
                        m1_data_o <= ram_we_o ? '0 : ram_data_i;
                    end else begin
                        m0_ack_o  <= 1'b1;
                        m0_data_o <= ram_we_o ? '0 : ram_data_i;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    m0_ack_o  <= 1'b0;
                    m1_ack_o  <= 1'b0;
                    m0_data_o <= '0;
                    m1_data_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
